// File: rtl/accel_pkg.sv
// Shared accelerator package: width defaults common to the tile loader and the
// store engine, tile element-count derivation and the store_v FSM state type.
package accel_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 24;
    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned TILE_WIDTH_DEF = 256;

    // Vector length field and the written-element counter. The counter has one
    // extra bit so a full 1023-element vector, padded or not, never wraps.
    localparam int unsigned LEN_WIDTH = 10;
    localparam int unsigned CNT_WIDTH = LEN_WIDTH + 1;

    function automatic int unsigned elem_count(input int unsigned tile_w,
                                               input int unsigned data_w);
        return tile_w / data_w;
    endfunction

    typedef enum logic [2:0] {
        StIdle,
        StWaitTile,
        StWriting,
        StNextTile,
        StDone
    } store_v_state_t;

endpackage

// File: rtl/store_v_tile_buf.sv
// Tile holding buffer for the store engine. Captures a whole tile in one
// cycle when capture is high and presents one element through an indexed
// read mux.
//   clk, rst_n : clock, asynchronous active-low reset (buffer clears to 0)
//   capture    : load tile_in into the buffer on this rising edge
//   tile_in    : ELEM_COUNT packed elements, element i at bits [i*DATA_WIDTH +: DATA_WIDTH]
//   rd_idx     : element select
//   rd_data    : selected element
module store_v_tile_buf import accel_pkg::*; #(
    parameter int unsigned TILE_WIDTH = TILE_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    localparam int unsigned ELEM_COUNT = elem_count(TILE_WIDTH, DATA_WIDTH),
    localparam int unsigned IDX_WIDTH  = $clog2(ELEM_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  capture,
    input  logic [TILE_WIDTH-1:0] tile_in,
    input  logic [IDX_WIDTH-1:0]  rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] tile_q [ELEM_COUNT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ELEM_COUNT; i++) begin
                tile_q[i] <= '0;
            end
        end else if (capture) begin
            for (int unsigned i = 0; i < ELEM_COUNT; i++) begin
                tile_q[i] <= tile_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign rd_data = tile_q[rd_idx];

endmodule

// File: rtl/store_v.sv
// Vector store engine. Latches a DRAM base address and element count on a
// start pulse, takes the vector as TILE_WIDTH-bit tiles from the writeback
// path and writes them one element per accepted cycle to the byte-wide memory
// port, then pulses valid_out.
//   clk, rst_n           : clock, asynchronous active-low reset
//   valid_in             : start pulse, only honoured while idle
//   dram_addr, length    : base byte address and element count, latched on start
//   tile_in, tile_valid  : incoming tile (element 0 at the lowest address)
//   tile_ready           : engine is waiting for a tile
//   tile_done            : one-cycle pulse after the last write of each tile
//   valid_out            : one-cycle pulse when the whole vector is written
//   busy                 : engine is not idle
//   mem_we, mem_addr, mem_wdata, mem_ready : memory write port with handshake
// Build option: define STORE_V_ZERO_PAD_EN to pad the final partial tile with
// zero writes up to a full tile; otherwise writing stops at exactly length.
module store_v import accel_pkg::*; #(
    parameter int unsigned TILE_WIDTH = TILE_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_in,
    input  logic [ADDR_WIDTH-1:0] dram_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    input  logic [TILE_WIDTH-1:0] tile_in,
    input  logic                  tile_valid,
    output logic                  tile_ready,
    output logic                  tile_done,
    output logic                  valid_out,
    output logic                  busy,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready
);

    localparam int unsigned ELEM_COUNT = elem_count(TILE_WIDTH, DATA_WIDTH);
    localparam int unsigned IDX_WIDTH  = $clog2(ELEM_COUNT);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(ELEM_COUNT - 1);

    store_v_state_t        state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [CNT_WIDTH-1:0]  wr_cnt_q, wr_cnt_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;

    logic                  start;
    logic                  tile_accept;
    logic                  wr_accept;
    logic                  elem_last;
    logic                  more_left;
    logic                  last_write;
    logic [DATA_WIDTH-1:0] buf_data;

    assign start       = (state_q == StIdle) && valid_in;
    assign tile_accept = (state_q == StWaitTile) && tile_valid;
    assign wr_accept   = (state_q == StWriting) && mem_ready;
    assign elem_last   = (idx_q == LAST_IDX);
    // True while the element about to be written lies inside the vector.
    assign more_left   = (wr_cnt_q < {1'b0, len_q});

`ifdef STORE_V_ZERO_PAD_EN
    // Always finish the whole tile; slots past length are written as zero.
    assign last_write = elem_last;
    assign mem_wdata  = more_left ? buf_data : '0;
`else
    logic len_reached;
    assign len_reached = ((wr_cnt_q + CNT_WIDTH'(1)) == {1'b0, len_q});
    assign last_write  = elem_last || len_reached;
    assign mem_wdata   = buf_data;
`endif

    store_v_tile_buf #(
        .TILE_WIDTH (TILE_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_tile_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .capture (tile_accept),
        .tile_in (tile_in),
        .rd_idx  (idx_q),
        .rd_data (buf_data)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            len_q    <= '0;
            wr_cnt_q <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            wr_cnt_q <= wr_cnt_d;
            idx_q    <= idx_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (valid_in) begin
                    state_d = (length == '0) ? StDone : StWaitTile;
                end
            end
            StWaitTile: begin
                if (tile_valid) begin
                    state_d = StWriting;
                end
            end
            StWriting: begin
                if (mem_ready && last_write) begin
                    state_d = StNextTile;
                end
            end
            StNextTile: begin
                state_d = more_left ? StWaitTile : StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Datapath next-state: address, length, written count, element index.
    // A stalled write (mem_ready low) leaves everything untouched.
    always_comb begin
        addr_d   = addr_q;
        len_d    = len_q;
        wr_cnt_d = wr_cnt_q;
        idx_d    = idx_q;
        if (start) begin
            addr_d   = dram_addr;
            len_d    = length;
            wr_cnt_d = '0;
        end
        if (tile_accept) begin
            idx_d = '0;
        end
        if (wr_accept) begin
            addr_d   = addr_q + ADDR_WIDTH'(1);
            wr_cnt_d = wr_cnt_q + CNT_WIDTH'(1);
            if (!last_write) begin
                idx_d = idx_q + IDX_WIDTH'(1);
            end
        end
    end

    // Moore outputs.
    always_comb begin
        tile_ready = (state_q == StWaitTile);
        tile_done  = (state_q == StNextTile);
        valid_out  = (state_q == StDone);
        busy       = (state_q != StIdle);
        mem_we     = (state_q == StWriting);
    end

    assign mem_addr = addr_q;

endmodule

// File: tb/tb_store_v.sv
// Self-checking bench for store_v: table of directed transactions plus hand
// sequences for a delayed/changing tile and a reset in the middle of a write.
module tb_store_v;

    localparam int TW = 256;
    localparam int EC = 32;
`ifdef STORE_V_ZERO_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_in;
    logic [23:0]   dram_addr;
    logic [9:0]    length;
    logic [TW-1:0] tile_in;
    logic          tile_valid;
    logic          tile_ready;
    logic          tile_done;
    logic          valid_out;
    logic          busy;
    logic          mem_we;
    logic [23:0]   mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_ready;

    store_v dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .dram_addr  (dram_addr),
        .length     (length),
        .tile_in    (tile_in),
        .tile_valid (tile_valid),
        .tile_ready (tile_ready),
        .tile_done  (tile_done),
        .valid_out  (valid_out),
        .busy       (busy),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: samples on the falling edge; a write is logged when it
    // will be accepted on the following rising edge.
    logic [23:0] wr_a [$];
    logic [7:0]  wr_d [$];
    int          td_cnt, vo_cnt, tr_cnt, tr_first, vo_c, stall_bad;
    bit          prev_stall;
    logic [23:0] p_a;
    logic [7:0]  p_d;
    bit          mon_clr = 1'b0;

    always @(negedge clk) begin
        if (mon_clr) begin
            wr_a.delete();
            wr_d.delete();
            td_cnt     <= 0;
            vo_cnt     <= 0;
            tr_cnt     <= 0;
            tr_first   <= -1;
            vo_c       <= -1;
            stall_bad  <= 0;
            prev_stall <= 1'b0;
        end else if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (mem_we !== 1'b1 || mem_addr !== p_a || mem_wdata !== p_d)) begin
                stall_bad <= stall_bad + 1;
            end
            if (mem_we && mem_ready) begin
                wr_a.push_back(mem_addr);
                wr_d.push_back(mem_wdata);
            end
            prev_stall <= mem_we && !mem_ready;
            p_a        <= mem_addr;
            p_d        <= mem_wdata;
            if (tile_done) td_cnt <= td_cnt + 1;
            if (valid_out) begin
                vo_cnt <= vo_cnt + 1;
                vo_c   <= cyc;
            end
            if (tile_ready) begin
                tr_cnt <= tr_cnt + 1;
                if (tr_first < 0) tr_first <= cyc;
            end
        end
    end

    int n_tot  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, got, exp);
    endtask

    function automatic logic [TW-1:0] mk_tile(input int k, input int seed);
        logic [TW-1:0] t;
        for (int i = 0; i < EC; i++) t[i*8 +: 8] = 8'(k*EC + i + 1 + seed);
        return t;
    endfunction

    typedef struct {
        logic [23:0] addr;
        int          len;
        int          seed;
        int          rmode;        // 0: mem_ready high, 1: toggles 1,0,1,0
        int          tdelay;       // cycles of tile_ready before tile_valid
        bit          noise;        // random valid_in/addr/length while busy
        int          exp_nw;
        int          exp_td;
        int          exp_lat;      // last tile accept -> valid_out, -1 skips
        int          exp_vo_start; // start -> valid_out, -1 skips
    } vec_t;

    int r_start, r_acc_first, r_acc_last, r_to;

    task automatic run_txn(input vec_t v, input bit change);
        int  k, wait_cnt, tail;
        bit  acc, done;
        @(posedge clk); #1;
        mon_clr    = 1'b1;
        valid_in   = 1'b1;
        dram_addr  = v.addr;
        length     = 10'(v.len);
        tile_valid = 1'b0;
        tile_in    = mk_tile(0, v.seed);
        mem_ready  = 1'b1;
        @(negedge clk);
        r_start     = cyc;
        k           = 0;
        wait_cnt    = 0;
        acc         = 1'b0;
        done        = 1'b0;
        tail        = 0;
        r_acc_first = -1;
        r_acc_last  = -1;
        r_to        = 1;
        for (int n = 0; n < 4000; n++) begin
            @(posedge clk); #1;
            mon_clr = 1'b0;
            if (v.noise && !done) begin
                valid_in  = 1'($urandom);
                dram_addr = 24'($urandom);
                length    = 10'($urandom);
            end else begin
                valid_in  = 1'b0;
                dram_addr = 24'hABCDEF;
                length    = 10'd999;
            end
            if (acc) begin
                acc      = 1'b0;
                k++;
                wait_cnt = 0;
                tile_in  = change ? {EC{8'hEE}} : mk_tile(k, v.seed);
            end
            tile_valid = (wait_cnt >= v.tdelay);
            mem_ready  = (v.rmode == 0) ? 1'b1 : 1'((n % 2) == 0);
            @(negedge clk);
            if (tile_ready) begin
                if (tile_valid) begin
                    acc = 1'b1;
                    if (r_acc_first < 0) r_acc_first = cyc;
                    r_acc_last = cyc;
                end else begin
                    wait_cnt++;
                end
            end
            if (done) begin
                tail++;
                if (tail == 3) begin
                    r_to = 0;
                    break;
                end
            end else if (valid_out) begin
                done = 1'b1;
            end
        end
        tile_valid = 1'b0;
        mem_ready  = 1'b1;
    endtask

    task automatic check_vec(input vec_t v, input string tag);
        int          bad, lim;
        logic [23:0] ea;
        logic [7:0]  ed;
        chk($sformatf("%s timeout", tag), r_to, 0);
        chk($sformatf("%s nwrites", tag), wr_a.size(), v.exp_nw);
        bad = 0;
        lim = (wr_a.size() < v.exp_nw) ? wr_a.size() : v.exp_nw;
        for (int j = 0; j < lim; j++) begin
            ea = 24'(v.addr + 24'(j));
            ed = (j < v.len) ? 8'(j + 1 + v.seed) : 8'h00;
            if (wr_a[j] !== ea || wr_d[j] !== ed) bad++;
        end
        chk($sformatf("%s write_mismatches", tag), bad, 0);
        chk($sformatf("%s tile_done_pulses", tag), td_cnt, v.exp_td);
        chk($sformatf("%s valid_out_pulses", tag), vo_cnt, 1);
        chk($sformatf("%s stall_hold_errors", tag), stall_bad, 0);
        chk($sformatf("%s busy_after", tag), busy, 1'b0);
        if (v.exp_lat >= 0) chk($sformatf("%s accept_to_valid_out", tag), vo_c - r_acc_last, v.exp_lat);
        if (v.exp_vo_start >= 0) chk($sformatf("%s start_to_valid_out", tag), vo_c - r_start, v.exp_vo_start);
        if (v.len == 0) chk($sformatf("%s tile_ready_cycles", tag), tr_cnt, 0);
        else chk($sformatf("%s start_to_tile_ready", tag), tr_first - r_start, 1);
    endtask

    vec_t vecs [7];
    vec_t vb, vc;
    int   hit;

    initial begin
        vecs[0] = '{24'h000100, 32, 0, 0, 0, 1'b0, 32, 1, 34, 35};
        vecs[1] = '{24'h000400, 40, 7, 0, 0, 1'b0, PAD ? 64 : 40, 2, PAD ? 34 : 10, PAD ? 69 : 45};
        vecs[2] = '{24'h000500, 0, 0, 0, 0, 1'b0, 0, 0, -1, 1};
        vecs[3] = '{24'h000600, 32, 3, 1, 0, 1'b0, 32, 1, -1, -1};
        vecs[4] = '{24'hFFFFF0, 20, 9, 0, 0, 1'b0, PAD ? 32 : 20, 1, PAD ? 34 : 22, PAD ? 35 : 23};
        vecs[5] = '{24'h000700, 33, 11, 0, 2, 1'b1, PAD ? 64 : 33, 2, PAD ? 34 : 3, -1};
        vecs[6] = '{24'h010000, 1023, 5, 0, 0, 1'b0, PAD ? 1024 : 1023, 32, PAD ? 34 : 33, -1};

        rst_n      = 1'b0;
        valid_in   = 1'b0;
        dram_addr  = '0;
        length     = '0;
        tile_in    = '0;
        tile_valid = 1'b0;
        mem_ready  = 1'b1;
        #12;
        chk("reset tile_ready", tile_ready, 1'b0);
        chk("reset tile_done", tile_done, 1'b0);
        chk("reset valid_out", valid_out, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset mem_we", mem_we, 1'b0);
        chk("reset mem_addr", mem_addr, 24'h0);
        chk("reset mem_wdata", mem_wdata, 8'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i], 1'b0);
            check_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Tile offered 5 cycles late, producer changes tile_in right after accept.
        vb = '{24'h000800, 32, 20, 0, 5, 1'b0, 32, 1, 34, -1};
        run_txn(vb, 1'b1);
        check_vec(vb, "delayed_tile");
        chk("delayed_tile accept_cycle", r_acc_first - r_start, 6);

        // Reset in the middle of WRITING, then a fresh transfer.
        @(posedge clk); #1;
        mon_clr    = 1'b1;
        valid_in   = 1'b1;
        dram_addr  = 24'h000200;
        length     = 10'd32;
        tile_in    = mk_tile(0, 0);
        tile_valid = 1'b1;
        mem_ready  = 1'b1;
        @(posedge clk); #1;
        mon_clr  = 1'b0;
        valid_in = 1'b0;
        hit = 0;
        for (int n = 0; n < 200; n++) begin
            if (wr_a.size() >= 10) begin
                hit = 1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("midreset reached_10_writes", hit, 1);
        chk("midreset writes_before", wr_a.size(), 10);
        chk("midreset busy_before", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset mem_we", mem_we, 1'b0);
        chk("midreset busy", busy, 1'b0);
        chk("midreset tile_ready", tile_ready, 1'b0);
        chk("midreset mem_addr", mem_addr, 24'h0);
        tile_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        vc = '{24'h000300, 5, 2, 0, 0, 1'b0, PAD ? 32 : 5, 1, PAD ? 34 : 7, PAD ? 35 : 8};
        run_txn(vc, 1'b0);
        check_vec(vc, "after_reset");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
